// File: rtl/window_generator_3x3.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 register window over a raster pixel stream.
// Optional WINGEN_FRAME_CNT_EN adds a 16-bit completed-frame counter output (frame_count).
module window_generator_3x3 #(
    parameter int unsigned BIT_PER_PIXEL = 8,
    parameter int unsigned IMG_WIDTH     = 640,
    parameter int unsigned IMG_HEIGHT    = 480,
    parameter int unsigned COL_BITS      = 10,
    parameter int unsigned ROW_BITS      = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [BIT_PER_PIXEL-1:0] in_pixel,
    output logic                     out_valid,
    output logic [BIT_PER_PIXEL-1:0] pixel_0,
    output logic [BIT_PER_PIXEL-1:0] pixel_1,
    output logic [BIT_PER_PIXEL-1:0] pixel_2,
    output logic [BIT_PER_PIXEL-1:0] pixel_3,
    output logic [BIT_PER_PIXEL-1:0] pixel_4,
    output logic [BIT_PER_PIXEL-1:0] pixel_5,
    output logic [BIT_PER_PIXEL-1:0] pixel_6,
    output logic [BIT_PER_PIXEL-1:0] pixel_7,
    output logic [BIT_PER_PIXEL-1:0] pixel_8,
    output logic                     frame_done,
    output logic                     sof_err
`ifdef WINGEN_FRAME_CNT_EN
    ,
    output logic [15:0]              frame_count
`endif
);

    localparam int unsigned PW = BIT_PER_PIXEL;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);
    localparam logic [COL_BITS-1:0] MIN_COL  = COL_BITS'(2);
    localparam logic [ROW_BITS-1:0] MIN_ROW  = ROW_BITS'(2);

    logic [PW-1:0] lb_a [IMG_WIDTH];
    logic [PW-1:0] lb_b [IMG_WIDTH];

    logic [COL_BITS-1:0] col_q;
    logic [ROW_BITS-1:0] row_q;

    logic [COL_BITS-1:0] cur_col;
    logic [ROW_BITS-1:0] cur_row;
    logic [COL_BITS-1:0] col_d;
    logic [ROW_BITS-1:0] row_d;
    logic                at_origin;
    logic                last_col;
    logic                last_row;
    logic                interior;
    logic [PW-1:0]       lb_a_rd;
    logic [PW-1:0]       lb_b_rd;

    // Position of the pixel on the input this cycle; in_sof forces (0,0).
    always_comb begin
        cur_col   = col_q;
        cur_row   = row_q;
        if (in_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
        at_origin = (col_q == '0) && (row_q == '0);
        last_col  = (cur_col == LAST_COL);
        last_row  = (cur_row == LAST_ROW);
        interior  = (cur_row >= MIN_ROW) && (cur_col >= MIN_COL);
        col_d     = cur_col + COL_BITS'(1);
        row_d     = cur_row;
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : cur_row + ROW_BITS'(1);
        end
        lb_a_rd   = lb_a[cur_col];
        lb_b_rd   = lb_b[cur_col];
    end

    // Line buffers shift one row down per accepted pixel; contents are not reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_a[cur_col] <= lb_b_rd;
            lb_b[cur_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q      <= '0;
            row_q      <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            out_valid  <= in_valid && interior;
            frame_done <= in_valid && last_row && last_col;
            sof_err    <= in_valid && in_sof && !at_origin;
            if (in_valid) begin
                col_q <= col_d;
                row_q <= row_d;
            end
        end
    end

    // Window shifts left; new right column is {row r-2, row r-1, row r} at the current column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_0 <= '0;
            pixel_1 <= '0;
            pixel_2 <= '0;
            pixel_3 <= '0;
            pixel_4 <= '0;
            pixel_5 <= '0;
            pixel_6 <= '0;
            pixel_7 <= '0;
            pixel_8 <= '0;
        end else if (in_valid) begin
            pixel_0 <= pixel_1;
            pixel_1 <= pixel_2;
            pixel_2 <= lb_a_rd;
            pixel_3 <= pixel_4;
            pixel_4 <= pixel_5;
            pixel_5 <= lb_b_rd;
            pixel_6 <= pixel_7;
            pixel_7 <= pixel_8;
            pixel_8 <= in_pixel;
        end
    end

`ifdef WINGEN_FRAME_CNT_EN
    // Completed-frame counter, advancing on the same edge that raises frame_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
        end else if (in_valid && last_row && last_col) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule
